// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: state encodings, timing defaults
// and the requester-index to one-hot helper.
package uart_tx_arbiter_pkg;

  localparam int CLKS_PER_BIT_DEF = 217;
  localparam int TIMEOUT_BITS     = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  function automatic logic [1:0] req_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; a held frame lock restricts the
// choice to the lock owner.
module uart_tx_arbiter_rr_arb2
  import uart_tx_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       pointer,
  input  logic       lock,
  input  logic       lock_owner,
  output logic [1:0] grant
);

  // One-hot winner selection
  always_comb begin
    grant = 2'b00;
    if (lock) begin
      if (valid[lock_owner]) begin
        grant = req_onehot(lock_owner);
      end else begin
        grant = 2'b00;
      end
    end else begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = req_onehot(pointer);
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX serializer between two byte-stream requesters with
// round-robin arbitration, frame locking and a done watchdog.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEF,
  parameter int TIMEOUT_CLKS   = TIMEOUT_BITS * CLKS_PER_BIT,
  parameter int LOCK_IDLE_CLKS = 4096
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Req0_Valid,
  input  logic [7:0] i_Req0_Byte,
  input  logic       i_Req0_Last,
  output logic       o_Req0_Ready,
  input  logic       i_Req1_Valid,
  input  logic [7:0] i_Req1_Byte,
  input  logic       i_Req1_Last,
  output logic       o_Req1_Ready,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  input  logic       i_TX_Active,
  input  logic       i_TX_Done,
  output logic [1:0] o_Grant,
  output logic       o_Timeout_Err
);

  localparam int WDOG_W = $clog2(TIMEOUT_CLKS + 1);
  localparam int IDLE_W = (LOCK_IDLE_CLKS > 0) ? $clog2(LOCK_IDLE_CLKS + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CLKS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((LOCK_IDLE_CLKS > 0) ? LOCK_IDLE_CLKS - 1 : 0);
  localparam bit LOCK_TIMEOUT_EN = (LOCK_IDLE_CLKS > 0);

  logic [1:0]        state_r;
  logic              ptr_r;
  logic              lock_r;
  logic              owner_r;
  logic              win_r;
  logic              last_r;
  logic [WDOG_W-1:0] wdog_r;
  logic [IDLE_W-1:0] idle_r;
  logic              tx_dv_r;
  logic [7:0]        tx_byte_r;
  logic [1:0]        grant_r;
  logic [1:0]        ready_r;
  logic              timeout_r;

  logic [1:0] valid_s;
  logic [1:0] pick_s;
  logic       win_idx_s;
  logic [7:0] win_byte_s;
  logic       win_last_s;
  logic       owner_valid_s;

  assign valid_s       = {i_Req1_Valid, i_Req0_Valid};
  assign win_idx_s     = pick_s[1];
  assign win_byte_s    = win_idx_s ? i_Req1_Byte : i_Req0_Byte;
  assign win_last_s    = win_idx_s ? i_Req1_Last : i_Req0_Last;
  assign owner_valid_s = valid_s[owner_r];

  uart_tx_arbiter_rr_arb2 u_rr_arb2 (
    .valid      (valid_s),
    .pointer    (ptr_r),
    .lock       (lock_r),
    .lock_owner (owner_r),
    .grant      (pick_s)
  );

  // Arbiter FSM, frame lock, watchdog and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r   <= ST_IDLE;
      ptr_r     <= 1'b0;
      lock_r    <= 1'b0;
      owner_r   <= 1'b0;
      win_r     <= 1'b0;
      last_r    <= 1'b0;
      wdog_r    <= '0;
      idle_r    <= '0;
      tx_dv_r   <= 1'b0;
      tx_byte_r <= 8'h00;
      grant_r   <= 2'b00;
      ready_r   <= 2'b00;
      timeout_r <= 1'b0;
    end else begin
      tx_dv_r   <= 1'b0;
      ready_r   <= 2'b00;
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // An owner that stays silent too long forfeits its lock
          if (lock_r && !owner_valid_s && LOCK_TIMEOUT_EN) begin
            if (idle_r == IDLE_LAST) begin
              lock_r  <= 1'b0;
              ptr_r   <= ~owner_r;
              idle_r  <= '0;
              grant_r <= 2'b00;
            end else begin
              idle_r <= idle_r + 1'b1;
            end
          end else begin
            idle_r <= '0;
          end
          if (!i_TX_Active && (pick_s != 2'b00)) begin
            tx_byte_r <= win_byte_s;
            grant_r   <= pick_s;
            win_r     <= win_idx_s;
            last_r    <= win_last_s;
            tx_dv_r   <= 1'b1;
            ready_r   <= pick_s;
            state_r   <= ST_SEND;
          end
        end
        ST_SEND: begin
          wdog_r <= '0;
          if (last_r) begin
            lock_r <= 1'b0;
            ptr_r  <= ~win_r;
          end else begin
            lock_r  <= 1'b1;
            owner_r <= win_r;
          end
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_TX_Done) begin
            wdog_r  <= '0;
            grant_r <= lock_r ? req_onehot(owner_r) : 2'b00;
            state_r <= ST_IDLE;
          end else if (wdog_r == WDOG_LAST) begin
            timeout_r <= 1'b1;
            lock_r    <= 1'b0;
            ptr_r     <= ~win_r;
            wdog_r    <= '0;
            grant_r   <= 2'b00;
            state_r   <= ST_IDLE;
          end else begin
            wdog_r <= wdog_r + 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign o_TX_DV       = tx_dv_r;
  assign o_TX_Byte     = tx_byte_r;
  assign o_Req0_Ready  = ready_r[0];
  assign o_Req1_Ready  = ready_r[1];
  assign o_Grant       = grant_r;
  assign o_Timeout_Err = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a cycle-counting UART_TX stand-in
// (10 bits of 4 clocks each) and a frame-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int CPB      = 4;
  localparam int TX_CLKS  = 10 * CPB;
  localparam int TMO      = 12 * CPB;
  localparam int LOCK_CLK = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0 = 1'b0, l0 = 1'b0, v1 = 1'b0, l1 = 1'b0;
  logic [7:0] b0 = 8'h00, b1 = 8'h00;
  logic       active = 1'b0, done = 1'b0;
  logic       r0, r1, tx_dv, terr;
  logic [7:0] tx_byte;
  logic [1:0] grant;

  uart_tx_arbiter #(
    .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO), .LOCK_IDLE_CLKS(LOCK_CLK)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Req0_Valid(v0), .i_Req0_Byte(b0), .i_Req0_Last(l0), .o_Req0_Ready(r0),
    .i_Req1_Valid(v1), .i_Req1_Byte(b1), .i_Req1_Last(l1), .o_Req1_Ready(r1),
    .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .i_TX_Active(active), .i_TX_Done(done),
    .o_Grant(grant), .o_Timeout_Err(terr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [7:0] b0;
    logic       v1;
    logic [7:0] b1;
    logic [7:0] exp_byte;
    logic [1:0] exp_grant;
  } vec_t;

  vec_t       vecs[8];
  logic [8:0] q0[$], q1[$], exp_q[$];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, dv_cyc = 0, dv_count = 0, err_cyc = 0, err_count = 0;
  int last_done_cyc = 0, tx_cnt = 0;
  bit done_seen = 1'b0, lat_en = 1'b1, done_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic drive();
    v0 = (q0.size() > 0);
    v1 = (q1.size() > 0);
    if (q0.size() > 0) {l0, b0} = q0[0]; else {l0, b0} = 9'h000;
    if (q1.size() > 0) {l1, b1} = q1[0]; else {l1, b1} = 9'h000;
  endtask

  // One clock: observe outputs, score DV events, advance the TX model, re-drive requesters
  task automatic tick();
    logic [8:0] e;
    @(posedge clk); #1;
    cyc++;
    done = 1'b0;
    if (tx_dv) begin
      dv_count++;
      dv_cyc = cyc;
      chk("dv_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_byte", tx_byte, e[7:0]);
        chk("grant_on_dv", grant, e[8] ? 2'b10 : 2'b01);
        chk("ready_on_dv", {r1, r0}, e[8] ? 2'b10 : 2'b01);
      end
      if (lat_en && done_seen) chk("dv_after_done", cyc - last_done_cyc, 32'd2);
      done_seen = 1'b0;
    end else if (r0 || r1) begin
      chk("ready_without_dv", {r1, r0}, 2'b00);
    end
    if (terr) begin
      err_count++;
      err_cyc = cyc;
    end
    if (r0 && q0.size() > 0) e = q0.pop_front();
    if (r1 && q1.size() > 0) e = q1.pop_front();
    if (tx_dv) begin
      tx_cnt = TX_CLKS;
      active = 1'b1;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        active = 1'b0;
        if (done_en) begin
          done = 1'b1;
          last_done_cyc = cyc;
          done_seen = 1'b1;
        end
      end
    end
    drive();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    q0.delete(); q1.delete(); exp_q.delete();
    active = 1'b0; done = 1'b0; tx_cnt = 0; done_seen = 1'b0;
    lat_en = 1'b1; done_en = 1'b1;
    drive();
    #1;
    chk("reset_outputs", {tx_dv, tx_byte, r0, r1, grant, terr}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_dv(input int budget);
    int start;
    start = dv_count;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dv_count != start) break;
    end
    chk("dv_arrives", dv_count - start, 32'd1);
  endtask

  task automatic wait_all(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && tx_cnt == 0 && q0.size() == 0 && q1.size() == 0) break;
      tick();
    end
    chk("drain", exp_q.size(), 32'd0);
    tick();
  endtask

  // Frame-level round robin: whole frames alternate, the side just served yields
  task automatic model_order(input logic start_ptr);
    logic [8:0] a0[$], a1[$];
    logic [8:0] e;
    logic p, sel;
    a0 = q0;
    a1 = q1;
    p = start_ptr;
    while (a0.size() > 0 || a1.size() > 0) begin
      if (a0.size() > 0 && a1.size() > 0) sel = p;
      else sel = (a0.size() > 0) ? 1'b0 : 1'b1;
      do begin
        e = sel ? a1.pop_front() : a0.pop_front();
        exp_q.push_back({sel, e[7:0]});
      end while (!e[8] && (sel ? a1.size() : a0.size()) > 0);
      p = ~sel;
    end
  endtask

  initial begin
    int push_cyc, base, k, err0, fall_cyc, nf, len;
    vecs[0] = '{1'b1, 8'h41, 1'b0, 8'h00, 8'h41, 2'b01};
    vecs[1] = '{1'b1, 8'h55, 1'b1, 8'hAA, 8'hAA, 2'b10};
    vecs[2] = '{1'b1, 8'h13, 1'b1, 8'h24, 8'h13, 2'b01};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 8'h7E, 8'h7E, 2'b10};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h80, 8'h80, 2'b10};
    vecs[5] = '{1'b1, 8'hC3, 1'b1, 8'h3C, 8'hC3, 2'b01};
    vecs[6] = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'hFF, 2'b01};
    vecs[7] = '{1'b1, 8'h00, 1'b1, 8'h5A, 8'h5A, 2'b10};

    // Single-byte table: latency, winner, idle grant
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].v0) q0.push_back({1'b1, vecs[i].b0});
      if (vecs[i].v1) q1.push_back({1'b1, vecs[i].b1});
      exp_q.push_back({vecs[i].exp_grant[1], vecs[i].exp_byte});
      drive();
      push_cyc = cyc;
      wait_dv(10);
      chk("vec_latency", dv_cyc - push_cyc, 32'd1);
      q0.delete(); q1.delete(); drive();
      for (int j = 0; j < 60; j++) begin
        if (tx_cnt == 0) break;
        tick();
      end
      tick();
      chk("vec_grant_idle", grant, 2'b00);
    end

    // Both requesters busy with single-byte frames
    reset_dut();
    q0.push_back({1'b1, 8'h55}); q0.push_back({1'b1, 8'h55});
    q1.push_back({1'b1, 8'hAA});
    model_order(1'b0);
    drive();
    base = dv_count;
    wait_all(400);
    chk("rr_dv_count", dv_count - base, 32'd3);

    // Frame lock: req1 frame is never interleaved with req0
    reset_dut();
    q1.push_back({1'b0, 8'h10}); q1.push_back({1'b0, 8'h11}); q1.push_back({1'b1, 8'h12});
    exp_q.push_back({1'b1, 8'h10}); exp_q.push_back({1'b1, 8'h11});
    exp_q.push_back({1'b1, 8'h12}); exp_q.push_back({1'b0, 8'h55});
    drive();
    base = dv_count;
    tick();
    q0.push_back({1'b1, 8'h55});
    drive();
    for (int i = 0; i < 400; i++) begin
      k = dv_count - base;
      if (k >= 4) break;
      if (k >= 1 && (k < 3 || tx_cnt > 0)) chk("frame_lock_grant", grant, 2'b10);
      tick();
    end
    chk("frame_dvs", dv_count - base, 32'd4);
    wait_all(200);

    // Lock released after LOCK_CLK idle cycles of a silent owner
    reset_dut();
    lat_en = 1'b0;
    q1.push_back({1'b0, 8'h20});
    exp_q.push_back({1'b1, 8'h20}); exp_q.push_back({1'b0, 8'h55});
    drive();
    wait_dv(10);
    q0.push_back({1'b1, 8'h55});
    drive();
    for (int j = 0; j < 60; j++) begin
      if (tx_cnt == 0) break;
      tick();
    end
    for (int j = 0; j < LOCK_CLK; j++) begin
      tick();
      chk("locked_blocked", {tx_dv, grant}, 3'b010);
    end
    tick();
    chk("released_grant", {tx_dv, grant}, 3'b000);
    tick();
    chk("release_dv", {tx_dv, grant}, 3'b101);
    wait_all(200);

    // Watchdog: no done ever arrives
    reset_dut();
    lat_en = 1'b0;
    done_en = 1'b0;
    q0.push_back({1'b1, 8'h66});
    exp_q.push_back({1'b0, 8'h66});
    drive();
    wait_dv(10);
    err0 = err_count;
    for (int j = 0; j < 100; j++) begin
      tick();
      if (err_count != err0) break;
    end
    chk("timeout_cycle", err_cyc - dv_cyc, TMO + 1);
    chk("timeout_grant", grant, 2'b00);
    for (int j = 0; j < 5; j++) tick();
    chk("timeout_single_pulse", err_count - err0, 32'd1);
    done_en = 1'b1;
    q0.push_back({1'b1, 8'h77});
    exp_q.push_back({1'b0, 8'h77});
    drive();
    push_cyc = cyc;
    wait_dv(10);
    chk("after_timeout_latency", dv_cyc - push_cyc, 32'd1);
    wait_all(200);

    // Reset during WAIT while the serializer keeps running
    reset_dut();
    lat_en = 1'b0;
    q0.push_back({1'b1, 8'h31});
    exp_q.push_back({1'b0, 8'h31});
    drive();
    wait_dv(10);
    for (int j = 0; j < 3; j++) tick();
    chk("pre_reset_grant", grant, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {tx_dv, tx_byte, r0, r1, grant, terr}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    q0.push_back({1'b1, 8'h32});
    exp_q.push_back({1'b0, 8'h32});
    drive();
    fall_cyc = 0;
    for (int j = 0; j < 60; j++) begin
      tick();
      if (!active) begin
        fall_cyc = cyc;
        break;
      end
      chk("no_dv_while_active", tx_dv, 1'b0);
    end
    tick();
    chk("dv_after_active_falls", {tx_dv, 32'(cyc - fall_cyc)}, {1'b1, 32'd1});
    wait_all(200);

    // Randomized frames against the frame-level model
    for (int round = 0; round < 3; round++) begin
      reset_dut();
      for (int side = 0; side < 2; side++) begin
        nf = $urandom_range(4, 1);
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(3, 1);
          for (int b = 0; b < len; b++) begin
            if (side == 0) q0.push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
            else q1.push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
          end
        end
      end
      model_order(1'b0);
      drive();
      wait_all(3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
